// File: rtl/yasac_run_ctrl.sv
// yasac_run_ctrl: host-side run sequencer for the YASAC core (reset pulse, setup, start, watchdog wait, capture)
module yasac_run_ctrl #(
    parameter int SETUP_CYCLES = 3,
    parameter int TIMEOUT      = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [63:0] in_vec,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic [63:0] result,
    output logic [15:0] cycles,
    output logic        cpu_reset,
    output logic        cpu_start,
    input  logic        cpu_ready,
    input  logic [63:0] cpu_out,
    output logic [63:0] cpu_in
);
    localparam int CW = $clog2(SETUP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CRST, ARM, START, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] setup_cnt;
    logic [15:0]   cycles_inc;
    logic          expired;

    assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
    assign expired    = cycles_inc >= 16'(TIMEOUT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = run ? CRST : IDLE;
            CRST:    state_nx = ARM;
            ARM:     state_nx = (setup_cnt == '0) ? START : ARM;
            START:   state_nx = WAIT;
            WAIT:    state_nx = (cpu_ready || expired) ? DONE : WAIT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            result    <= '0;
            cycles    <= '0;
            cpu_reset <= 1'b0;
            cpu_start <= 1'b0;
            cpu_in    <= '0;
            setup_cnt <= '0;
        end else begin
            busy      <= state_nx != IDLE;
            done      <= state_nx == DONE;
            cpu_reset <= state_nx == CRST;
            cpu_start <= state_nx == START;
            case (state)
                IDLE: if (run) begin
                    cpu_in    <= in_vec;
                    timed_out <= 1'b0;
                    cycles    <= '0;
                end
                CRST:  setup_cnt <= CW'(SETUP_CYCLES - 1);
                ARM:   if (setup_cnt != '0) setup_cnt <= setup_cnt - CW'(1);
                START: cycles <= 16'd1;
                WAIT: begin
                    cycles <= cycles_inc;
                    if (cpu_ready) result <= cpu_out;
                    else if (expired) timed_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
